// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and helpers for the parametrised serial sequence detector.
//   SEQ_OVL / SEQ_NOVL : values of the ovl mode input (overlap / non-overlap)
//   fillWidth(len)     : width of a counter able to hold 0..len
// ---------------------------------------------------------------------------
package seq_det_pkg;

    localparam logic SEQ_OVL  = 1'b1;
    localparam logic SEQ_NOVL = 1'b0;

    // The fill counter has to represent every value from 0 up to len
    // inclusive, hence the +1 before taking the log.
    function automatic int fillWidth(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// ---------------------------------------------------------------------------
// seq_match_counter
// Saturating event counter used to tally detector matches.
// Parameters:
//   CNT_W : counter width in bits (>= 1)
// Ports:
//   clk   in  1      rising-edge clock
//   clr_n in  1      asynchronous active-low reset
//   inc   in  1      count one event on this edge
//   clr   in  1      synchronous clear, has priority over inc
//   cnt   out CNT_W  current count, sticks at all-ones
// ---------------------------------------------------------------------------
module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a clear on the same edge as an increment wins, and the
    // count holds once it reaches all-ones instead of wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Count register, cleared asynchronously with the rest of the detector.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// ---------------------------------------------------------------------------
// seq_det_param
// Serial sequence detector with a runtime-loadable LEN-bit pattern, overlap /
// non-overlap modes and an optional saturating match counter.
// Build option:
//   SEQ_DET_MATCH_CNT_EN : when defined, match_cnt is a real saturating
//                          counter; when undefined it is tied to 0 and
//                          cnt_clr is ignored.
// Parameters:
//   LEN     : pattern length in bits (>= 2)
//   RST_PAT : pattern value loaded at reset
//   CNT_W   : match counter width (>= 1)
// Ports:
//   clk       in  1      rising-edge clock
//   clr_n     in  1      asynchronous active-low reset
//   x         in  1      serial data bit, first bit aligns with pattern MSB
//   x_valid   in  1      x is accepted on edges where this is high
//   ovl       in  1      1 = overlapping detection, 0 = non-overlapping
//   pat_in    in  LEN    new pattern value
//   pat_load  in  1      load pat_in and restart detection on this edge
//   cnt_clr   in  1      synchronous clear of the match counter
//   z         out 1      registered one-cycle match pulse
//   match_cnt out CNT_W  saturating number of matches
// ---------------------------------------------------------------------------
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] RST_PAT = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             ovl,
    input  logic [LEN-1:0]   pat_in,
    input  logic             pat_load,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                FILL_W    = fillWidth(LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    logic [LEN-1:0]    pat_q;
    logic [LEN-1:0]    pat_d;
    logic [LEN-1:0]    hist_q;
    logic [LEN-1:0]    hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              z_q;
    logic              z_d;

    logic [LEN-1:0]    shiftHist;
    logic [FILL_W-1:0] shiftFill;
    logic              matchHit;

    // Detection datapath. A pattern load restarts everything and swallows the
    // bit on that edge. Otherwise an accepted bit shifts in at the LSB so the
    // oldest bit ends up in the MSB, matching the pattern's bit order. fill
    // tells us whether hist holds LEN genuine bits yet, which stops the
    // zeroed history from matching a pattern that starts with zeros. In
    // non-overlap mode a match empties fill so the next match needs a fresh
    // LEN bits; hist itself is left alone since fill alone gates the compare.
    always_comb begin
        pat_d     = pat_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        shiftHist = {hist_q[LEN-2:0], x};
        shiftFill = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FILL_ONE);
        matchHit  = 1'b0;
        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            matchHit = (shiftFill == FILL_FULL) && (shiftHist == pat_q);
            hist_d   = shiftHist;
            if (matchHit && (ovl == SEQ_NOVL)) begin
                fill_d = '0;
            end else begin
                fill_d = shiftFill;
            end
        end
        z_d = matchHit;
    end

    // State registers. z is rebuilt every edge from that edge's match, so it
    // is never stretched across idle (x_valid low) cycles.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pat_q  <= RST_PAT;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    assign z = z_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    // Match counter advances on the same edge that raises z.
    seq_match_counter #(
        .CNT_W(CNT_W)
    ) u_matchCounter (
        .clk  (clk),
        .clr_n(clr_n),
        .inc  (matchHit),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );
`else
    // Counter not built: the output reads zero and the clear has no effect.
    logic unusedCntClr;
    assign unusedCntClr = cnt_clr;
    assign match_cnt    = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// ---------------------------------------------------------------------------
// tb_seq_det_param
// Directed bench for seq_det_param with LEN=4 and reset pattern 1011. A
// second instance with a 2-bit counter shares all inputs so counter
// saturation is visible alongside the normal-width count.
// ---------------------------------------------------------------------------
module tb_seq_det_param;

    logic       clk;
    logic       clr_n;
    logic       x;
    logic       x_valid;
    logic       ovl;
    logic [3:0] pat_in;
    logic       pat_load;
    logic       cnt_clr;
    logic       z;
    logic [7:0] match_cnt;
    logic       zSmall;
    logic [1:0] matchCntSmall;

    int compareCount;
    int mismatchCount;
    int expMatches;

    seq_det_param #(
        .LEN    (4),
        .RST_PAT(4'b1011),
        .CNT_W  (8)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .x        (x),
        .x_valid  (x_valid),
        .ovl      (ovl),
        .pat_in   (pat_in),
        .pat_load (pat_load),
        .cnt_clr  (cnt_clr),
        .z        (z),
        .match_cnt(match_cnt)
    );

    seq_det_param #(
        .LEN    (4),
        .RST_PAT(4'b1011),
        .CNT_W  (2)
    ) dutSmall (
        .clk      (clk),
        .clr_n    (clr_n),
        .x        (x),
        .x_valid  (x_valid),
        .ovl      (ovl),
        .pat_in   (pat_in),
        .pat_load (pat_load),
        .cnt_clr  (cnt_clr),
        .z        (zSmall),
        .match_cnt(matchCntSmall)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected counter values for the wide and the 2-bit instance.
    function automatic int expBig(input int m);
`ifdef SEQ_DET_MATCH_CNT_EN
        return m;
`else
        return 0;
`endif
    endfunction

    function automatic int expSmall(input int m);
`ifdef SEQ_DET_MATCH_CNT_EN
        return (m > 3) ? 3 : m;
`else
        return 0;
`endif
    endfunction

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one clock of inputs at the falling edge, then sample 1 ns after
    // the rising edge that consumed them.
    task automatic applyStimulus(input logic xBit, input logic valid, input logic clrBit);
        @(negedge clk);
        x        = xBit;
        x_valid  = valid;
        cnt_clr  = clrBit;
        pat_load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Load a new pattern while presenting a bit that must be ignored.
    task automatic loadPattern(input logic [3:0] pat, input logic xBit, input logic valid);
        @(negedge clk);
        pat_in   = pat;
        pat_load = 1'b1;
        x        = xBit;
        x_valid  = valid;
        cnt_clr  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Check z plus both counters after a step; clrExp models a counter clear.
    task automatic checkStep(input logic expZ, input logic clrExp, input string tag);
        checkOutput({tag, ".z"}, 32'(z), 32'(expZ));
        checkOutput({tag, ".zSmall"}, 32'(zSmall), 32'(expZ));
        if (clrExp) begin
            expMatches = 0;
        end else if (expZ) begin
            expMatches++;
        end
        checkOutput({tag, ".cnt"}, 32'(match_cnt), 32'(expBig(expMatches)));
        checkOutput({tag, ".cntSmall"}, 32'(matchCntSmall), 32'(expSmall(expMatches)));
    endtask

    // Feed n valid bits MSB first; zs holds the hand-computed z after each.
    task automatic runStream(input logic [15:0] bits, input logic [15:0] zs,
                             input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(bits[i], 1'b1, 1'b0);
            checkStep(zs[i], 1'b0, $sformatf("%s.b%0d", tag, n - i));
        end
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        expMatches    = 0;
        clr_n    = 1'b0;
        x        = 1'b0;
        x_valid  = 1'b0;
        ovl      = 1'b1;
        pat_in   = 4'b0000;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;

        // Reset state.
        #3;
        checkStep(1'b0, 1'b0, "reset");
        @(negedge clk);
        clr_n = 1'b1;

        // Overlap mode: matches after bits 4 and 7.
        $display("[TB] overlap stream 1011011");
        ovl = 1'b1;
        runStream(16'b1011011, 16'b0001001, 7, "ovl");

        // Non-overlap mode: restart, match after bit 4 only, bit 8 no match.
        $display("[TB] non-overlap stream 10110111");
        loadPattern(4'b1011, 1'b0, 1'b0);
        checkStep(1'b0, 1'b0, "novl.load");
        ovl = 1'b0;
        runStream(16'b10110111, 16'b00010000, 8, "novl");

        // Valid gaps: history survives idle cycles, no z while idle.
        $display("[TB] valid gaps");
        loadPattern(4'b1011, 1'b0, 1'b0);
        checkStep(1'b0, 1'b0, "gap.load");
        ovl = 1'b1;
        runStream(16'b10, 16'b00, 2, "gapA");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkStep(1'b0, 1'b0, "gap.idle1");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkStep(1'b0, 1'b0, "gap.idle2");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkStep(1'b0, 1'b0, "gap.idle3");
        runStream(16'b11, 16'b01, 2, "gapB");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkStep(1'b0, 1'b0, "gap.noStretch");

        // Reload mid-pattern: bit on load edge ignored, new pattern 0110.
        $display("[TB] reload to 0110");
        runStream(16'b101, 16'b000, 3, "reloadA");
        loadPattern(4'b0110, 1'b1, 1'b1);
        checkStep(1'b0, 1'b0, "reload.load");
        runStream(16'b0110, 16'b0001, 4, "reloadB");

        // Asynchronous reset while z is high: everything clears at once.
        $display("[TB] asynchronous reset");
        #2;
        clr_n = 1'b0;
        #1;
        checkStep(1'b0, 1'b1, "asyncRst");
        @(negedge clk);
        clr_n = 1'b1;

        // Pattern back to 1011 after reset.
        ovl = 1'b1;
        runStream(16'b1011, 16'b0001, 4, "postRst");

        // Counter: keep matching (2-bit instance saturates), then clear on a
        // match edge, then confirm counting resumes.
        $display("[TB] counter saturation and clear");
        runStream(16'b011011011, 16'b001001001, 9, "sat");
        runStream(16'b01, 16'b00, 2, "clrA");
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkStep(1'b1, 1'b1, "clrOnMatch");
        runStream(16'b011, 16'b001, 3, "afterClr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial sequence detector, the successor to the fixed-pattern `seq` detector. It samples a 1-bit serial stream `x` under a sample-valid qualifier and compares it against a runtime-loadable pattern of `LEN` bits. It supports overlapping and non-overlapping detection and keeps an optional saturating match counter. It sits on a serial input path and feeds a one-cycle match pulse `z` to downstream control.

## Interface
- `LEN`, default 4: pattern length in bits, ≥2.
- `RST_PAT`, default 4'b1011: pattern value loaded at reset, `LEN` bits wide.
- `CNT_W`, default 8: match counter width, ≥1.
- `clk`  in  1  rising-edge clock; the only clock.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `x`  in  1  serial data bit.
- `x_valid`  in  1  `x` is sampled on an edge where this is 1.
- `ovl`  in  1  mode select: 1 = overlapping detection, 0 = non-overlapping.
- `pat_in`  in  LEN  new pattern value.
- `pat_load`  in  1  load `pat_in` on this edge.
- `cnt_clr`  in  1  synchronous clear of the match counter.
- `z`  out  1  registered match pulse.
- `match_cnt`  out  CNT_W  saturating count of matches.

## Operation
- Internal state:
  - `pat`: pattern register, LEN bits.
  - `hist`: shift history, LEN bits.
  - `fill`: count of valid bits accepted, 0..LEN, saturates at LEN, width $clog2(LEN+1).
- Bit order: the first-received bit of a match aligns with `pat[LEN-1]` (MSB first).
- Shift on an edge with `x_valid`=1 and `pat_load`=0:
  - hist_nx = {hist[LEN-2:0], x}
  - fill_nx = min(fill+1, LEN)
- Match condition: fill_nx==LEN and hist_nx==pat.
- On a match:
  - `z` is 1 for the following cycle.
  - If `ovl`=0, `fill` is forced to 0, so LEN fresh bits are required before the next match.
  - If `ovl`=1, `fill` stays at LEN and the next bit can complete a new match.
- On any edge with no match, `z` is 0. This includes edges with `x_valid`=0, because `z` is never stretched.
- Pattern load (`pat_load`=1):
  - `pat` ← `pat_in`, `hist` ← 0, `fill` ← 0, `z` ← 0.
  - `x` is ignored on that edge even if `x_valid`=1.
  - `match_cnt` is unaffected.
- `ovl` is sampled on every match edge. A mode change mid-stream takes effect at the next match.
- Reset (`clr_n` low), asynchronous, at any time including mid-pattern:
  - `pat` = RST_PAT, `hist` = 0, `fill` = 0, `z` = 0, `match_cnt` = 0.
- Counter: increments by 1 on every match edge and saturates at 2^CNT_W−1. `cnt_clr` and a match on the same edge give 0 (clear wins).

## Timing
- `z` latency: one edge. `z` rises on the same edge that accepts the final pattern bit and stays high exactly one clock period.
- `match_cnt` updates on that same edge.
- No handshake back-pressure. `x_valid` gaps simply pause detection; history is retained across gaps.
- Minimum spacing between `z` pulses:
  - 1 valid bit in overlap mode (e.g. all-ones pattern on an all-ones stream).
  - LEN valid bits in non-overlap mode.
- Release of `clr_n` is synchronised externally. The first sample is the first `x_valid` edge after deassertion.

## Configuration
- `SEQ_DET_MATCH_CNT_EN` defined: the match counter is built as described above.
- Undefined:
  - No counter flops are built.
  - `match_cnt` is tied to 0.
  - `cnt_clr` is ignored.
  - Detection and `z` are unchanged.

## Structure
- `seq_det_pkg` holds:
  - mode constants `SEQ_OVL` = 1'b1 and `SEQ_NOVL` = 1'b0;
  - the function computing fill width from LEN.
- One sub-module, `seq_match_counter` (parameter CNT_W; ports clk, clr_n, inc, clr, cnt). It is instantiated only under `SEQ_DET_MATCH_CNT_EN`.
- The top level holds `pat`, `hist`, `fill`, the compare and `z`.

## Test plan
All scenarios use LEN=4 with pattern 1011 unless stated; `x_valid`=1 throughout unless stated.
- **Reset:** drive `clr_n`=0 mid-stream with `fill`=3 → `z`=0, `match_cnt`=0, pattern back to 1011. After release, stream 1011 → `z` pulses after the 4th bit only.
- **Overlap:** `ovl`=1, stream 1,0,1,1,0,1,1 → `z` high after bits 4 and 7, each for 1 cycle; `match_cnt`=2.
- **Non-overlap:** `ovl`=0, same stream → `z` high after bit 4 only; `match_cnt`=1. Continue with 1 (8th bit) → no `z`.
- **Valid gaps:** stream 1,0,[x_valid=0 for 3 cycles with x toggling],1,1 → `z` pulses only on the edge accepting the final 1; no `z` during the gap.
- **Reload:** after bits 1,0,1, pulse `pat_load` with `pat_in`=0110 and `x_valid`=1 → that bit is ignored and no `z` follows. Then stream 0,1,1,0 → `z` after the 4th bit.
- **Counter:** CNT_W=2 with the macro defined, 5 matches → `match_cnt`=3 (saturated). Assert `cnt_clr` on a match edge → `match_cnt`=0. Rebuild without the macro → `match_cnt` stays 0.
